// File: rtl/ps16_bus_arbiter_pkg.sv
// Shared definitions for the PiStorm16 bus arbiter: state encodings,
// the default grant timeout and the Pi status-bit position of ext_master.
package ps16_pkg;

    localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
    localparam logic [2:0] ST_PENDING_ENC = 3'd1;
    localparam logic [2:0] ST_GRANT_ENC   = 3'd2;
    localparam logic [2:0] ST_OWNED_ENC   = 3'd3;
    localparam logic [2:0] ST_RECLAIM_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_PENDING = ST_PENDING_ENC,
        ST_GRANT   = ST_GRANT_ENC,
        ST_OWNED   = ST_OWNED_ENC,
        ST_RECLAIM = ST_RECLAIM_ENC
    } arbState_e;

    localparam int GRANT_TIMEOUT_DEFAULT = 16;

    localparam int PI_STATUS_EXT_MASTER_BIT = 3;

    // Enough bits to hold the count value equal to the limit itself.
    function automatic int timerWidth(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ps16_bus_arbiter_if.sv
// Handshake bundle between the arbiter (master modport) and the
// edge synchronizer / access engine side (slave modport).
interface ps16_bus_arbiter_if #(
    parameter int CNT_W = 8
);

    logic             mc_clk_rising;
    logic             mc_clk_falling;
    logic             br_n;
    logic             bgack_n;
    logic             as_n;
    logic             start_req;
    logic             cycle_active;
    logic             start_grant;
    logic             bg_drive;
    logic             bus_released;
    logic             ext_master;
    logic             grant_timeout;
    logic [CNT_W-1:0] grant_count;

    modport master (
        input  mc_clk_rising,
        input  mc_clk_falling,
        input  br_n,
        input  bgack_n,
        input  as_n,
        input  start_req,
        input  cycle_active,
        output start_grant,
        output bg_drive,
        output bus_released,
        output ext_master,
        output grant_timeout,
        output grant_count
    );

    modport slave (
        output mc_clk_rising,
        output mc_clk_falling,
        output br_n,
        output bgack_n,
        output as_n,
        output start_req,
        output cycle_active,
        input  start_grant,
        input  bg_drive,
        input  bus_released,
        input  ext_master,
        input  grant_timeout,
        input  grant_count
    );

endinterface

// File: rtl/ps16_bus_arbiter.sv
// 68000-style bus arbitration controller: grants the Amiga bus to external
// DMA masters via nBG and holds the Pi access engine off the bus meanwhile.
module ps16_bus_arbiter
    import ps16_pkg::*;
#(
    parameter int GRANT_TIMEOUT = GRANT_TIMEOUT_DEFAULT,
    parameter int CNT_W         = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    ps16_bus_arbiter_if.master  bus
);

    localparam int TMR_W = timerWidth(GRANT_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(GRANT_TIMEOUT);

    arbState_e        state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [TMR_W-1:0] timerInc;
    logic [CNT_W-1:0] grantCount_q, grantCount_d;
    logic             timeoutPulse_d;

    logic startGrant_q;
    logic bgDrive_q;
    logic busReleased_q;
    logic extMaster_q;
    logic grantTimeout_q;

    assign timerInc = timer_q + TMR_W'(1);

    // Bus-line inputs are only consulted together with the falling strobe,
    // so they are effectively sampled on the CLK_7M falling edge.
    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        grantCount_d   = grantCount_q;
        timeoutPulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.mc_clk_falling && !bus.br_n)
                    state_d = ST_PENDING;
            end

            ST_PENDING: begin
                if (bus.mc_clk_falling && bus.br_n) begin
                    state_d = ST_IDLE;
                end else if (bus.mc_clk_rising && !bus.cycle_active) begin
                    state_d = ST_GRANT;
                    timer_d = '0;
                end
            end

            ST_GRANT: begin
                if (bus.mc_clk_falling && !bus.bgack_n) begin
                    state_d      = ST_OWNED;
                    grantCount_d = grantCount_q + CNT_W'(1);
                end else if (bus.mc_clk_falling && bus.br_n) begin
                    state_d = ST_IDLE;
                end else if (bus.mc_clk_rising) begin
                    timer_d = timerInc;
                    if (timerInc == TMR_LIMIT) begin
                        state_d        = ST_IDLE;
                        timeoutPulse_d = 1'b1;
                    end
                end
            end

            // The master only really leaves once both BGACK and AS are released.
            ST_OWNED: begin
                if (bus.mc_clk_falling && bus.bgack_n && bus.as_n) begin
                    if (!bus.br_n) begin
                        state_d = ST_GRANT;
                        timer_d = '0;
                    end else begin
                        state_d = ST_RECLAIM;
                    end
                end
            end

            ST_RECLAIM: begin
                if (bus.mc_clk_rising)
                    state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state so every output
    // moves exactly one sys_clk after its qualifying strobe.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            grantCount_q   <= '0;
            startGrant_q   <= 1'b0;
            bgDrive_q      <= 1'b0;
            busReleased_q  <= 1'b0;
            extMaster_q    <= 1'b0;
            grantTimeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            grantCount_q   <= grantCount_d;
            startGrant_q   <= (state_d == ST_IDLE);
            bgDrive_q      <= (state_d == ST_GRANT);
            busReleased_q  <= (state_d == ST_GRANT) || (state_d == ST_OWNED) ||
                              (state_d == ST_RECLAIM);
            extMaster_q    <= (state_d == ST_OWNED);
            grantTimeout_q <= timeoutPulse_d;
        end
    end

    assign bus.start_grant   = startGrant_q;
    assign bus.bg_drive      = bgDrive_q;
    assign bus.bus_released  = busReleased_q;
    assign bus.ext_master    = extMaster_q;
    assign bus.grant_timeout = grantTimeout_q;
    assign bus.grant_count   = grantCount_q;

endmodule

// File: doc/ps16_bus_arbiter.md
# ps16_bus_arbiter

68000-style bus arbitration controller for the PiStorm16 bus engine. It observes the Amiga-side nBR/nBGACK/nAS lines and sequences the Pi access state machine around external bus masters. It gates the start of each Pi-originated bus cycle, drives nBG, and forces the engine to release the address, data and strobe buses while a DMA master owns the bus. It sits between the 7 MHz edge synchronizer and the access state machine inside the top level.

## Interface
Parameters:
- GRANT_TIMEOUT, 16: MC-clock rising edges to wait for nBGACK after asserting nBG before withdrawing the grant.
- CNT_W, 8: width of the grant counter.

Ports:
- sys_clk  in  1  system clock (PLL output); sole clock.
- sys_rst  in  1  reset, synchronous, active-high.
- mc_clk_rising  in  1  one-sys_clk strobe on the CLK_7M rising edge.
- mc_clk_falling  in  1  one-sys_clk strobe on the CLK_7M falling edge.
- br_n  in  1  synchronized nBR_IN, active low.
- bgack_n  in  1  synchronized nBGACK_IN, active low.
- as_n  in  1  synchronized bus nAS, active low.
- start_req  in  1  access engine has a pending request and is in S0.
- cycle_active  in  1  access engine is between leaving S0 and completing S7.
- start_grant  out  1  engine may leave S0.
- bg_drive  out  1  1 = drive nBG low (feeds nBG_OE).
- bus_released  out  1  engine must hold A/FC/D/AS/RW/UDS/LDS/VMA output enables at 0.
- ext_master  out  1  an external master owns the bus (status bit to Pi).
- grant_timeout  out  1  one-cycle pulse when a grant is withdrawn by timeout.
- grant_count  out  CNT_W  number of grants that an external master accepted; wraps.

## Operation
States: IDLE, PENDING, GRANT, OWNED, RECLAIM.
- Sample br_n, bgack_n and as_n only on mc_clk_falling. Evaluate all transitions except the timeout only on mc_clk_falling or mc_clk_rising, as listed below.
- IDLE: start_grant = 1. On mc_clk_falling with br_n = 0, go to PENDING.
- PENDING: start_grant = 0.
  - On mc_clk_falling with br_n = 1, return to IDLE (request withdrawn).
  - Otherwise, on mc_clk_rising with cycle_active = 0, go to GRANT, set bg_drive = 1 and clear the timeout counter.
- GRANT: bg_drive = 1, bus_released = 1. The timeout counter increments on each mc_clk_rising.
  - On mc_clk_falling with bgack_n = 0, go to OWNED, clear bg_drive and increment grant_count.
  - On mc_clk_falling with br_n = 1 and bgack_n = 1, go to IDLE and clear bg_drive.
  - When the counter reaches GRANT_TIMEOUT, go to IDLE, clear bg_drive and pulse grant_timeout.
- OWNED: ext_master = 1, bus_released = 1, bg_drive = 0.
  - On mc_clk_falling with bgack_n = 1 and as_n = 1: if br_n = 0, go to GRANT (re-grant, counter cleared); otherwise go to RECLAIM.
  - While bgack_n = 1 but as_n = 0, stay in OWNED.
- RECLAIM: bus_released = 1. On the next mc_clk_rising, go to IDLE. This gives one full MC phase of bus turnaround.
- start_req only qualifies the grant. The arbiter never queues Pi requests; the engine holds start_req until it is granted.
- Simultaneous BR sample and start_req in IDLE: the grant is already registered, so a cycle that leaves S0 on the same sys_clk completes. PENDING waits for cycle_active = 0.
- grant_count wraps modulo 2^CNT_W.

## Timing
- All outputs are registered. Each changes one sys_clk after its qualifying strobe.
- While sys_rst is high, all outputs are 0, the state is IDLE, and the timeout counter and grant_count are 0.
- On the first sys_clk after reset deasserts, start_grant = 1.
- Reset mid-grant: bg_drive and bus_released drop on the cycle after sys_rst is sampled high.
- Best-case BR-to-BG latency with no cycle active: one falling strobe plus the next rising strobe, about 70 ns plus 1 sys_clk.
- An active cycle delays BG until the first mc_clk_rising after cycle_active falls.
- BG negates within 1 sys_clk after the mc_clk_falling that samples bgack_n = 0.
- Timeout fires on the GRANT_TIMEOUT-th mc_clk_rising after entering GRANT.

## Structure
- Shared package ps16_pkg holds:
  - state localparams (3-bit encoding: IDLE = 0, PENDING = 1, GRANT = 2, OWNED = 3, RECLAIM = 4);
  - the GRANT_TIMEOUT default;
  - the status-bit index of ext_master within pi_status.
- Single module; the timeout counter and grant counter are inline. No sub-module is needed.

## Test plan
- Idle bus, br_n low for 1 falling strobe -> bg_drive rises at the next mc_clk_rising. Then bgack_n low -> bg_drive falls, ext_master = 1, grant_count = 1.
- br_n low while cycle_active = 1 for 6 MC phases -> bg_drive stays 0 until the first rising strobe after cycle_active = 0; start_grant = 0 throughout.
- GRANT with bgack_n held high and br_n low -> grant_timeout pulses once at the 16th rising strobe, bg_drive = 0, state IDLE, grant_count unchanged.
- OWNED, bgack_n high with as_n still low for 3 phases -> stays OWNED. Then as_n high and br_n high -> RECLAIM; start_grant returns to 1 one rising strobe later.
- OWNED, bgack_n high with br_n low -> direct re-grant, bg_drive = 1 and no start_grant pulse. After 256 accepted grants, grant_count wraps to 0.
- sys_rst asserted during OWNED -> all outputs 0 next cycle; start_grant = 1 one cycle after release.
